// File: rtl/in_port_ctrl.sv
// Switch input port: debounces the load button, captures the switches on each accepted
// press and holds the word for the core until it is consumed.
module in_port_ctrl #(
   parameter int SW_WIDTH        = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SIGN_EXTEND     = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                btn,
   input  logic                in_read,
   output logic [31:0]         in_data,
   output logic                in_valid,
   output logic                overrun,
   output logic                btn_state
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                capture;
   logic                btn_state_nxt;
   logic                btn_meta, sync_btn;
   logic [SW_WIDTH-1:0] sw_meta, sync_sw;
   logic [31:0]         ext_sw;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta <= 1'b0;
         sync_btn <= 1'b0;
         sw_meta  <= '0;
         sync_sw  <= '0;
      end else begin
         btn_meta <= btn;
         sync_btn <= btn_meta;
         sw_meta  <= sw;
         sync_sw  <= sw_meta;
      end
   end

   generate
      if (SW_WIDTH == 32) begin : g_full
         assign ext_sw = sync_sw;
      end else if (SIGN_EXTEND != 0) begin : g_sext
         assign ext_sw = {{(32-SW_WIDTH){sync_sw[SW_WIDTH-1]}}, sync_sw};
      end else begin : g_zext
         assign ext_sw = {{(32-SW_WIDTH){1'b0}}, sync_sw};
      end
   endgenerate

   // The counter holds the number of consecutive samples at the new level; a level
   // is accepted on the cycle the counter already equals DEBOUNCE_CYCLES.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (sync_btn) begin
               state_nxt = DB_PRESS;
               cnt_nxt   = CNT_ONE;
            end
         end
         DB_PRESS: begin
            if (!sync_btn) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
               capture   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync_btn) begin
               state_nxt = DB_RELEASE;
               cnt_nxt   = CNT_ONE;
            end
         end
         DB_RELEASE: begin
            if (sync_btn) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      btn_state_nxt = (state_nxt == PRESSED) || (state_nxt == DB_RELEASE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         btn_state <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_state <= btn_state_nxt;
      end
   end

   // Handshake: in_valid=1 means in_data holds an unconsumed word; the core pulses
   // in_read for one cycle to consume it. A capture in the same cycle as in_read loads
   // the new word and keeps in_valid high; a capture while the word is still pending
   // keeps the old word and sets the sticky overrun flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_data  <= '0;
         in_valid <= 1'b0;
         overrun  <= 1'b0;
      end else if (capture) begin
         if (!in_valid || in_read) begin
            in_data  <= ext_sw;
            in_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (in_read) begin
         in_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_in_port_ctrl.sv
// Bench for in_port_ctrl: zero- and sign-extending instances share stimulus and are
// checked against a run-length debounce reference model and a word scoreboard.
module tb_in_port_ctrl;

   localparam int D = 4;

   logic        clk;
   logic        reset;
   logic [9:0]  sw;
   logic        btn;
   logic        in_read;
   logic [31:0] z_data, s_data;
   logic        z_valid, s_valid, z_ov, s_ov, z_bs, s_bs;

   int n_tests = 0;
   int n_fail  = 0;

   in_port_ctrl #(.SW_WIDTH(10), .DEBOUNCE_CYCLES(D), .SIGN_EXTEND(0)) dut_z (
      .clk(clk), .reset(reset), .sw(sw), .btn(btn), .in_read(in_read),
      .in_data(z_data), .in_valid(z_valid), .overrun(z_ov), .btn_state(z_bs)
   );

   in_port_ctrl #(.SW_WIDTH(10), .DEBOUNCE_CYCLES(D), .SIGN_EXTEND(1)) dut_s (
      .clk(clk), .reset(reset), .sw(sw), .btn(btn), .in_read(in_read),
      .in_data(s_data), .in_valid(s_valid), .overrun(s_ov), .btn_state(s_bs)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] zext(input logic [9:0] w);
      return {22'b0, w};
   endfunction

   function automatic logic [31:0] sext(input logic [9:0] w);
      return {{22{w[9]}}, w};
   endfunction

   // ---------------- reference model ----------------
   // Decisions see the button/switches as sampled two edges earlier. The debounced
   // level flips after DEBOUNCE_CYCLES+1 consecutive samples at the opposite level.
   logic [31:0] exp_z_q[$];
   logic [31:0] exp_s_q[$];
   logic        m_bh1, m_bh2, m_deb, m_valid, m_ov, m_s, m_cap;
   logic [9:0]  m_swh1, m_swh2, m_ws, m_word;
   int          m_run;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_bh1 = 0; m_bh2 = 0; m_swh1 = 0; m_swh2 = 0;
         m_deb = 0; m_run = 0; m_valid = 0; m_ov = 0; m_word = 0;
         exp_z_q.delete();
         exp_s_q.delete();
      end else begin
         m_s = m_bh2;
         m_ws = m_swh2;
         m_bh2 = m_bh1; m_bh1 = btn;
         m_swh2 = m_swh1; m_swh1 = sw;
         m_cap = 0;
         if (m_s != m_deb) begin
            m_run++;
            if (m_run == D + 1) begin
               m_deb = m_s;
               m_run = 0;
               m_cap = m_s;
            end
         end else begin
            m_run = 0;
         end
         if (m_cap) begin
            if (!m_valid || in_read) begin
               m_word = m_ws;
               m_valid = 1;
               exp_z_q.push_back(zext(m_ws));
               exp_s_q.push_back(sext(m_ws));
            end else begin
               m_ov = 1;
            end
         end else if (in_read) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic prev_z_valid = 0;
   int   dut_rise = 0;

   always @(negedge clk) begin
      #2;
      if (!reset) begin
         prev_z_valid = 0;
         dut_rise = 0;
      end else begin
         check("cyc_valid_z", z_valid, m_valid);
         check("cyc_valid_s", s_valid, m_valid);
         check("cyc_overrun_z", z_ov, m_ov);
         check("cyc_overrun_s", s_ov, m_ov);
         check("cyc_btn_state_z", z_bs, m_deb);
         check("cyc_btn_state_s", s_bs, m_deb);
         check("cyc_data_z", z_data, zext(m_word));
         check("cyc_data_s", s_data, sext(m_word));
         if (z_valid && !prev_z_valid) dut_rise++;
         prev_z_valid = z_valid;
         if (in_read && z_valid) begin
            if (exp_z_q.size() == 0 || exp_s_q.size() == 0) begin
               check("handshake_queue_empty", 32'd0, 32'd1);
            end else begin
               check("handshake_word_z", z_data, exp_z_q.pop_front());
               check("handshake_word_s", s_data, exp_s_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 0; btn = 0; in_read = 0;
      cycles(3);
      reset = 1;
   endtask

   task automatic press(input logic [9:0] val, input int hold);
      sw = val;
      cycles(3);
      btn = 1;
      cycles(hold);
      btn = 0;
      cycles(12);
   endtask

   task automatic read_pulse();
      @(negedge clk);
      in_read = 1;
      @(negedge clk);
      in_read = 0;
   endtask

   // Counts rising edges until in_valid is seen, starting just after a negedge.
   task automatic measure_latency(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (z_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   // ---------------- test sequence ----------------
   int lat;

   initial begin
      reset = 0; btn = 0; in_read = 0; sw = 0;
      #12;
      check("reset_data", z_data, 32'h0);
      check("reset_valid", z_valid, 1'b0);
      check("reset_overrun", z_ov, 1'b0);
      check("reset_btn_state", z_bs, 1'b0);
      apply_reset();

      // clean press: latency, data, single capture while held
      sw = 10'h155;
      cycles(3);
      btn = 1;
      measure_latency(lat);
      check("press_latency", lat, 7);
      check("press_data", z_data, 32'h00000155);
      cycles(13);
      check("held_btn_state", z_bs, 1'b1);
      check("held_single_capture", dut_rise, 1);
      btn = 0;
      cycles(10);
      read_pulse();

      // bounce: 2 high / 1 low / 2 high then low
      apply_reset();
      sw = 10'h02A;
      cycles(3);
      btn = 1; cycles(2); btn = 0; cycles(1); btn = 1; cycles(2); btn = 0;
      cycles(12);
      check("bounce_valid", z_valid, 1'b0);
      check("bounce_btn_state", z_bs, 1'b0);
      check("bounce_no_capture", dut_rise, 0);

      // overrun: second press while first word pending
      apply_reset();
      press(10'h0AA, 10);
      press(10'h3FF, 10);
      #2;
      check("overrun_data", z_data, 32'h000000AA);
      check("overrun_flag", z_ov, 1'b1);
      check("overrun_valid", z_valid, 1'b1);
      read_pulse();

      // sign extension and read
      apply_reset();
      press(10'h200, 8);
      #2;
      check("sext_data", s_data, 32'hFFFFFE00);
      check("zext_data", z_data, 32'h00000200);
      read_pulse();
      #2;
      check("read_valid_low", s_valid, 1'b0);
      check("read_data_held", s_data, 32'hFFFFFE00);

      // capture coinciding with in_read
      apply_reset();
      press(10'h001, 8);
      sw = 10'h002;
      cycles(4);
      btn = 1;
      cycles(6);
      in_read = 1;
      @(negedge clk);
      in_read = 0;
      #2;
      check("coincide_data", z_data, 32'h00000002);
      check("coincide_valid", z_valid, 1'b1);
      check("coincide_overrun", z_ov, 1'b0);
      btn = 0;
      cycles(12);
      read_pulse();

      // async reset during DB_PRESS with a pending word, button held through release
      apply_reset();
      sw = 10'h155;
      cycles(3);
      btn = 1; cycles(12); btn = 0; cycles(12);
      btn = 1; cycles(4);
      #1;
      reset = 0;
      #1;
      check("async_rst_data", z_data, 32'h0);
      check("async_rst_valid", z_valid, 1'b0);
      check("async_rst_overrun", z_ov, 1'b0);
      check("async_rst_btn_state", z_bs, 1'b0);
      cycles(2);
      reset = 1;
      measure_latency(lat);
      check("post_reset_latency", lat, 7);
      check("post_reset_data", z_data, 32'h00000155);
      btn = 0;
      cycles(12);
      read_pulse();

      // randomized bouncing, switches and reads
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) btn = ~btn;
         if ($urandom_range(0, 9) == 0) sw = 10'($urandom_range(0, 1023));
         in_read = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      in_read = 0;
      btn = 0;
      cycles(15);
      read_pulse();
      cycles(2);
      check("final_queue_empty", exp_z_q.size(), 0);
      check("final_valid", z_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
